// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative multiply/divide unit: operand width,
// op encodings and FSM state codes.
package muldiv_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_CALC = 2'd1;
  localparam state_t S_FIX  = 2'd2;
  localparam state_t S_DONE = 2'd3;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negation; purely combinational, no backpressure.
module muldiv_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] in_i,
  input  logic         neg_en_i,
  output logic [W-1:0] out_o
);

  assign out_o = neg_en_i ? (~in_i + {{(W-1){1'b0}}, 1'b1}) : in_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO; 34 cycles start-to-done (1 for div-by-zero), busy_o stalls.
// MULDIV_EARLY_OUT_EN shortens multiplies to the top set multiplier bit; results unchanged.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  input  logic            kill_i,
  input  logic            hi_we_i,
  input  logic            lo_we_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  state_t          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic [63:0]     acc_q, acc_d;
  logic [63:0]     b_q, b_d;
  logic [31:0]     mplier_q, mplier_d;
  logic            neg_res_q, neg_res_d;
  logic            neg_rem_q, neg_rem_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;

  logic            signed_in;
  logic [31:0]     abs_a, abs_b;
  logic [63:0]     prod_fix;
  logic [31:0]     quo_fix, rem_fix;
  logic [63:0]     mul_sum;
  logic [32:0]     rem_sh, rem_diff;
  logic            early_exit;

  assign signed_in = ~op_i[0];

  muldiv_negate #(.W(32)) u_abs_a (.in_i(src1_i), .neg_en_i(signed_in & src1_i[31]), .out_o(abs_a));
  muldiv_negate #(.W(32)) u_abs_b (.in_i(src2_i), .neg_en_i(signed_in & src2_i[31]), .out_o(abs_b));
  muldiv_negate #(.W(64)) u_prod  (.in_i(acc_q), .neg_en_i(neg_res_q), .out_o(prod_fix));
  muldiv_negate #(.W(32)) u_quo   (.in_i(acc_q[31:0]), .neg_en_i(neg_res_q), .out_o(quo_fix));
  muldiv_negate #(.W(32)) u_rem   (.in_i(acc_q[63:32]), .neg_en_i(neg_rem_q), .out_o(rem_fix));

  // Multiply adds a left-shifting multiplicand; divide shifts {rem, dividend} left one bit per step.
  assign mul_sum  = acc_q + (mplier_q[0] ? b_q : 64'd0);
  assign rem_sh   = acc_q[63:31];
  assign rem_diff = rem_sh - {1'b0, b_q[31:0]};

`ifdef MULDIV_EARLY_OUT_EN
  assign early_exit = ~op_q[1] & (mplier_q[31:1] == 31'd0);
`else
  assign early_exit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    acc_d     = acc_q;
    b_d       = b_q;
    mplier_d  = mplier_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      S_IDLE: begin
        if (hi_we_i) hi_d = wdata_i;
        if (lo_we_i) lo_d = wdata_i;
        if (start_i && !kill_i) begin
          op_d = op_i;
          if (op_i[1] && (src2_i == 32'd0)) begin
            hi_d    = src1_i;
            lo_d    = 32'hFFFF_FFFF;
            state_d = S_DONE;
          end else begin
            cnt_d     = 5'd0;
            neg_res_d = signed_in & (src1_i[31] ^ src2_i[31]);
            neg_rem_d = signed_in & op_i[1] & src1_i[31];
            acc_d     = op_i[1] ? {32'd0, abs_a} : 64'd0;
            b_d       = op_i[1] ? {32'd0, abs_b} : {32'd0, abs_a};
            mplier_d  = abs_b;
            state_d   = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (op_q[1]) begin
          acc_d = rem_diff[32] ? {rem_sh[31:0], acc_q[30:0], 1'b0}
                               : {rem_diff[31:0], acc_q[30:0], 1'b1};
        end else begin
          acc_d    = mul_sum;
          b_d      = {b_q[62:0], 1'b0};
          mplier_d = {1'b0, mplier_q[31:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if ((cnt_q == 5'd31) || early_exit) state_d = S_FIX;
      end
      S_FIX: begin
        if (op_q[1]) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // HI/LO are already committed on entry to DONE, so a kill there changes nothing.
    if (kill_i && (state_q == S_CALC || state_q == S_FIX)) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      op_q      <= 2'd0;
      acc_q     <= 64'd0;
      b_q       <= 64'd0;
      mplier_q  <= 32'd0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      mplier_q  <= mplier_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = (state_q == S_DONE);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed and random ops against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] src1_i, src2_i;
  logic        kill_i, hi_we_i, lo_we_i;
  logic [31:0] wdata_i;
  logic        busy_o, done_o;
  logic [31:0] hi_o, lo_o;

  int checks = 0;
  int errors = 0;

  logic [1:0]  dir_op [8];
  logic [31:0] dir_a  [8];
  logic [31:0] dir_b  [8];
  logic [31:0] dir_hi [8];
  logic [31:0] dir_lo [8];

  muldiv_unit dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .src1_i(src1_i), .src2_i(src2_i), .kill_i(kill_i),
    .hi_we_i(hi_we_i), .lo_we_i(lo_we_i), .wdata_i(wdata_i),
    .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference result {HI, LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] model_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sq, sm;
    longint unsigned ua, ub, uq, um;
    logic [63:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = 64'd0;
    if (op[1] && b == 32'd0) begin
      r = {a, 32'hFFFF_FFFF};
    end else begin
      case (op)
        2'b00: r = sa * sb;
        2'b01: r = ua * ub;
        2'b10: begin sq = sa / sb; sm = sa % sb; r = {sm[31:0], sq[31:0]}; end
        default: begin uq = ua / ub; um = ua % ub; r = {um[31:0], uq[31:0]}; end
      endcase
    end
    return r;
  endfunction

  // Cycles from the accepting edge to the cycle in which done_o is high.
  function automatic int model_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] m;
    int          k;
    m = a;  // a only matters for divides, whose latency is fixed
    k = 0;
    if (op[1] && b == 32'd0) return 1;
`ifdef MULDIV_EARLY_OUT_EN
    if (!op[1]) begin
      m = (op == 2'b00 && b[31]) ? (32'd0 - b) : b;
      for (int i = 0; i < 32; i++) if (m[i]) k = i;
      return k + 3;
    end
`endif
    return 34 + k;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Launches an op in the current (idle) cycle and returns at the done_o cycle or after a bound.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] hi, output logic [31:0] lo);
    start_i = 1'b1; op_i = op; src1_i = a; src2_i = b;
    step();
    start_i = 1'b0; op_i = 2'($urandom); src1_i = $urandom; src2_i = $urandom;
    lat = 1;
    while (done_o !== 1'b1 && lat < 200) begin
      step();
      lat++;
    end
    hi = hi_o;
    lo = lo_o;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    step(); step();
    rst_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_o); end
    checks++; if (hi_o !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", hi_o); end
    checks++; if (lo_o !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", lo_o); end
  endtask

  task automatic test_directed();
    int lat; logic [31:0] hi, lo;
    dir_op = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b11, 2'b01, 2'b11, 2'b00};
    dir_a  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h80000000, 32'd100, 32'd3, 32'hFFFFFFFF, 32'h80000000};
    dir_b  = '{32'd7, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'd0, 32'd5, 32'd1, 32'h80000000};
    dir_hi = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h64, 32'h0, 32'h0, 32'h40000000};
    dir_lo = '{32'hFFFFFFEB, 32'h00000001, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'd15, 32'hFFFFFFFF, 32'h0};
    for (int i = 0; i < 8; i++) begin
      run_op(dir_op[i], dir_a[i], dir_b[i], lat, hi, lo);
      checks++; if (hi !== dir_hi[i]) begin errors++; $display("FAIL dir%0d_hi got %h want %h", i, hi, dir_hi[i]); end
      checks++; if (lo !== dir_lo[i]) begin errors++; $display("FAIL dir%0d_lo got %h want %h", i, lo, dir_lo[i]); end
      checks++; if (lat != model_lat(dir_op[i], dir_a[i], dir_b[i])) begin
        errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, model_lat(dir_op[i], dir_a[i], dir_b[i]));
      end
      step();
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL dir%0d_idle_after busy=%b want 0", i, busy_o); end
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] hi, lo, a, b; logic [1:0] op; logic [63:0] exp;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(0, 15));
        2: b = 32'hFFFFFFFF;
        3: b = 32'd0 - 32'($urandom_range(1, 300));
        default: b = $urandom;
      endcase
      exp = model_res(op, a, b);
      run_op(op, a, b, lat, hi, lo);
      checks++; if (hi !== exp[63:32]) begin errors++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h got %h want %h", i, op, a, b, hi, exp[63:32]); end
      checks++; if (lo !== exp[31:0]) begin errors++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h got %h want %h", i, op, a, b, lo, exp[31:0]); end
      checks++; if (lat != model_lat(op, a, b)) begin errors++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, model_lat(op, a, b)); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] hi, lo; logic [63:0] exp;
    run_op(2'b11, 32'd1000, 32'd7, lat, hi, lo);
    step();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL b2b_idle busy=%b want 0", busy_o); end
    exp = model_res(2'b00, 32'hFFFF1234, 32'h00012345);
    run_op(2'b00, 32'hFFFF1234, 32'h00012345, lat, hi, lo);
    checks++; if ({hi, lo} !== exp) begin errors++; $display("FAIL b2b_result got %h want %h", {hi, lo}, exp); end
    checks++; if (lat != model_lat(2'b00, 32'hFFFF1234, 32'h00012345)) begin errors++; $display("FAIL b2b_latency got %0d", lat); end
    step();
  endtask

  task automatic test_kill();
    logic [31:0] hi_before; int lat; logic [31:0] hi, lo; logic seen_done; logic [63:0] exp;
    lo_we_i = 1'b1; wdata_i = 32'h1234;
    step();
    lo_we_i = 1'b0;
    checks++; if (lo_o !== 32'h1234) begin errors++; $display("FAIL mtlo got %h want 00001234", lo_o); end
    hi_before = hi_o;
    start_i = 1'b1; op_i = 2'b00; src1_i = 32'h87654321; src2_i = 32'h80000001;
    step();
    start_i = 1'b0;
    for (int c = 1; c < 10; c++) step();
    kill_i = 1'b1;
    step();
    kill_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL kill_idle busy=%b want 0", busy_o); end
    seen_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done_o === 1'b1) seen_done = 1'b1;
      step();
    end
    checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL kill_no_done saw done_o=1 want none"); end
    checks++; if (lo_o !== 32'h1234) begin errors++; $display("FAIL kill_lo got %h want 00001234", lo_o); end
    checks++; if (hi_o !== hi_before) begin errors++; $display("FAIL kill_hi got %h want %h", hi_o, hi_before); end
    // kill together with start in IDLE drops the start
    start_i = 1'b1; kill_i = 1'b1; op_i = 2'b11; src1_i = 32'd9; src2_i = 32'd0;
    step();
    start_i = 1'b0; kill_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL kill_start busy=%b want 0", busy_o); end
    // kill in DONE keeps the committed write
    exp = model_res(2'b10, 32'hFFFFFF00, 32'd9);
    run_op(2'b10, 32'hFFFFFF00, 32'd9, lat, hi, lo);
    kill_i = 1'b1;
    step();
    kill_i = 1'b0;
    checks++; if ({hi_o, lo_o} !== exp) begin errors++; $display("FAIL kill_done got %h want %h", {hi_o, lo_o}, exp); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL kill_done_idle busy=%b want 0", busy_o); end
  endtask

  task automatic test_busy_ignore();
    int lat; logic [31:0] hi_before; logic [63:0] exp;
    hi_before = hi_o;
    exp = model_res(2'b00, 32'hDEADBEEF, 32'hF0000007);
    start_i = 1'b1; op_i = 2'b00; src1_i = 32'hDEADBEEF; src2_i = 32'hF0000007;
    step();
    start_i = 1'b0;
    lat = 1;
    step(); lat++;
    start_i = 1'b1; op_i = 2'b11; src1_i = 32'd5; src2_i = 32'd0;
    hi_we_i = 1'b1; wdata_i = 32'hCAFEF00D;
    step(); lat++;
    start_i = 1'b0; hi_we_i = 1'b0;
    checks++; if (hi_o !== hi_before) begin errors++; $display("FAIL busy_mthi got %h want %h", hi_o, hi_before); end
    while (done_o !== 1'b1 && lat < 200) begin step(); lat++; end
    checks++; if (lat != model_lat(2'b00, 32'hDEADBEEF, 32'hF0000007)) begin errors++; $display("FAIL busy_latency got %0d", lat); end
    checks++; if ({hi_o, lo_o} !== exp) begin errors++; $display("FAIL busy_result got %h want %h", {hi_o, lo_o}, exp); end
    step();
    // MTHI alongside an accepted start lands now, the divide result replaces it later
    exp = model_res(2'b11, 32'd77777, 32'd13);
    start_i = 1'b1; op_i = 2'b11; src1_i = 32'd77777; src2_i = 32'd13;
    hi_we_i = 1'b1; wdata_i = 32'h0BADF00D;
    step();
    start_i = 1'b0; hi_we_i = 1'b0;
    checks++; if (hi_o !== 32'h0BADF00D) begin errors++; $display("FAIL mt_with_start got %h want 0badf00d", hi_o); end
    lat = 1;
    while (done_o !== 1'b1 && lat < 200) begin step(); lat++; end
    checks++; if ({hi_o, lo_o} !== exp) begin errors++; $display("FAIL mt_then_done got %h want %h", {hi_o, lo_o}, exp); end
    step();
  endtask

  task automatic test_reset_mid();
    start_i = 1'b1; op_i = 2'b01; src1_i = 32'hFFFFFFFF; src2_i = 32'h7FFFFFFF;
    step();
    start_i = 1'b0;
    for (int c = 1; c < 15; c++) step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    checks++; if ({busy_o, done_o} !== 2'b00) begin errors++; $display("FAIL midrst_flags got %b want 00", {busy_o, done_o}); end
    checks++; if ({hi_o, lo_o} !== 64'd0) begin errors++; $display("FAIL midrst_hilo got %h want 0", {hi_o, lo_o}); end
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; op_i = 2'b00; src1_i = 32'd0; src2_i = 32'd0;
    kill_i = 1'b0; hi_we_i = 1'b0; lo_we_i = 1'b0; wdata_i = 32'd0;
    #1;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_kill();
    test_busy_ignore();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
